// File: rtl/soldier_walker.sv
// soldier_walker: moves a sprite back and forth between two horizontal bounds.
// On each motion tick the sprite advances by `step` pixels. When it reaches a
// bound it is clamped to that bound and pulses `bounce`. It then waits
// PAUSE_TICKS+1 ticks; the last of those ticks reverses the heading.
// The renderer sees a position that is latched once per frame, so it never
// changes in the middle of a frame.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous, active-low reset
//   enable       walker active; low returns to IDLE
//   tick         one-cycle motion strobe
//   frame_start  one-cycle pulse at the start of vertical blank
//   dir_init     start heading (1 = right, 0 = left)
//   left_bound   minimum position
//   right_bound  maximum position
//   step         pixels per tick (0 = stationary)
//   pos_h        frame-latched position for the renderer
//   valid        sprite visible (frame-latched)
//   dir          current heading (1 = right)
//   bounce       one-cycle pulse when a bound is reached
module soldier_walker #(
   parameter int unsigned PAUSE_TICKS = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       enable,
   input  logic       tick,
   input  logic       frame_start,
   input  logic       dir_init,
   input  logic [9:0] left_bound,
   input  logic [9:0] right_bound,
   input  logic [3:0] step,
   output logic [9:0] pos_h,
   output logic       valid,
   output logic       dir,
   output logic       bounce
);

   localparam int unsigned POS_W = 10;
   localparam int unsigned CNT_W = 4;
   localparam int unsigned EXT_W = POS_W + 1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WALK_R = 2'd1,
      WALK_L = 2'd2,
      PAUSE  = 2'd3
   } state_t;

   state_t             state;
   logic [POS_W-1:0]   pos;
   logic [CNT_W-1:0]   pause_cnt;

   // One extra bit keeps pos+step from wrapping and lets pos-step go negative
   logic [EXT_W-1:0]        sum_r;
   logic signed [EXT_W-1:0] diff_l;
   logic                    hit_r;
   logic                    hit_l;

   assign sum_r  = {1'b0, pos} + {7'd0, step};
   assign diff_l = $signed({1'b0, pos}) - $signed({7'd0, step});
   assign hit_r  = (sum_r >= {1'b0, right_bound});
   assign hit_l  = (diff_l <= $signed({1'b0, left_bound}));

   // Walker state, internal position and all registered outputs
   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= IDLE;
         pos       <= '0;
         pause_cnt <= '0;
         pos_h     <= '0;
         valid     <= 1'b0;
         dir       <= 1'b1;
         bounce    <= 1'b0;
      end else begin
         bounce <= 1'b0;

         // Renderer copy uses pre-edge values so a coincident tick shows next frame
         if (frame_start) begin
            pos_h <= pos;
            valid <= (state != IDLE);
         end

         if (!enable) begin
            state     <= IDLE;
            pause_cnt <= '0;
         end else begin
            case (state)
               IDLE: begin
                  if (left_bound < right_bound) begin
                     pos       <= dir_init ? left_bound : right_bound;
                     dir       <= dir_init;
                     pause_cnt <= '0;
                     state     <= dir_init ? WALK_R : WALK_L;
                  end else begin
                     pos <= left_bound;
                  end
               end

               WALK_R: begin
                  if (tick) begin
                     if (hit_r) begin
                        pos    <= right_bound;
                        bounce <= 1'b1;
                        state  <= PAUSE;
                     end else begin
                        pos <= POS_W'(sum_r);
                     end
                  end
               end

               WALK_L: begin
                  if (tick) begin
                     if (hit_l) begin
                        pos    <= left_bound;
                        bounce <= 1'b1;
                        state  <= PAUSE;
                     end else begin
                        pos <= POS_W'(diff_l);
                     end
                  end
               end

               PAUSE: begin
                  // The tick that finds the count already at PAUSE_TICKS reverses
                  if (tick) begin
                     if (pause_cnt == CNT_W'(PAUSE_TICKS)) begin
                        pause_cnt <= '0;
                        dir       <= ~dir;
                        state     <= dir ? WALK_L : WALK_R;
                     end else begin
                        pause_cnt <= pause_cnt + CNT_W'(1);
                     end
                  end
               end

               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_soldier_walker.sv
// Bench for soldier_walker: two instances (PAUSE_TICKS 4 and 0) share one
// stimulus stream. A behavioural model predicts every output each cycle, and
// directed scenarios add hand-computed literal expectations.
module tb_soldier_walker;

   logic       clk = 1'b0;
   logic       rst;
   logic       enable;
   logic       tick;
   logic       frame_start;
   logic       dir_init;
   logic [9:0] left_bound;
   logic [9:0] right_bound;
   logic [3:0] step;

   logic [9:0] pos_h_a, pos_h_b;
   logic       valid_a, valid_b;
   logic       dir_a, dir_b;
   logic       bounce_a, bounce_b;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   soldier_walker #(.PAUSE_TICKS(4)) dut_a (
      .clk(clk), .rst(rst), .enable(enable), .tick(tick),
      .frame_start(frame_start), .dir_init(dir_init),
      .left_bound(left_bound), .right_bound(right_bound), .step(step),
      .pos_h(pos_h_a), .valid(valid_a), .dir(dir_a), .bounce(bounce_a)
   );

   soldier_walker #(.PAUSE_TICKS(0)) dut_b (
      .clk(clk), .rst(rst), .enable(enable), .tick(tick),
      .frame_start(frame_start), .dir_init(dir_init),
      .left_bound(left_bound), .right_bound(right_bound), .step(step),
      .pos_h(pos_h_b), .valid(valid_b), .dir(dir_b), .bounce(bounce_b)
   );

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, got, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // The walker is either inactive, walking, or resting at a bound. A rest
   // lasts pause_len+1 ticks, and the final tick of the rest turns it around.
   int pause_len [2] = '{4, 0};
   bit m_act [2];
   bit m_dir [2];
   bit m_resting [2];
   int m_rest_ticks [2];
   int m_pos [2];
   int m_ph [2];
   bit m_v [2];
   bit m_bnc [2];
   bit model_live = 1'b0;

   task automatic model_step(input int k);
      int np;
      if (!rst) begin
         m_act[k] = 0; m_dir[k] = 1; m_resting[k] = 0; m_rest_ticks[k] = 0;
         m_pos[k] = 0; m_ph[k] = 0; m_v[k] = 0; m_bnc[k] = 0;
         return;
      end
      m_bnc[k] = 0;
      if (frame_start) begin
         m_ph[k] = m_pos[k];
         m_v[k]  = m_act[k];
      end
      if (!enable) begin
         m_act[k] = 0; m_resting[k] = 0; m_rest_ticks[k] = 0;
      end else if (!m_act[k]) begin
         if (int'(left_bound) < int'(right_bound)) begin
            m_act[k] = 1;
            m_dir[k] = dir_init;
            m_pos[k] = dir_init ? int'(left_bound) : int'(right_bound);
            m_resting[k] = 0; m_rest_ticks[k] = 0;
         end else begin
            m_pos[k] = int'(left_bound);
         end
      end else if (tick) begin
         if (m_resting[k]) begin
            m_rest_ticks[k]++;
            if (m_rest_ticks[k] > pause_len[k]) begin
               m_resting[k] = 0; m_rest_ticks[k] = 0; m_dir[k] = !m_dir[k];
            end
         end else begin
            np = m_dir[k] ? m_pos[k] + int'(step) : m_pos[k] - int'(step);
            if (m_dir[k] && np >= int'(right_bound)) begin
               m_pos[k] = int'(right_bound); m_bnc[k] = 1; m_resting[k] = 1;
            end else if (!m_dir[k] && np <= int'(left_bound)) begin
               m_pos[k] = int'(left_bound); m_bnc[k] = 1; m_resting[k] = 1;
            end else begin
               m_pos[k] = np;
            end
         end
      end
   endtask

   initial begin
      forever begin
         @(posedge clk);
         model_step(0);
         model_step(1);
         model_live = 1'b1;
      end
   end

   // Per-cycle comparison of both instances against the model
   initial begin
      forever begin
         @(negedge clk);
         if (model_live) begin
            chk("a.pos_h",  32'(pos_h_a),  32'(m_ph[0]));
            chk("a.valid",  32'(valid_a),  32'(m_v[0]));
            chk("a.dir",    32'(dir_a),    32'(m_dir[0]));
            chk("a.bounce", 32'(bounce_a), 32'(m_bnc[0]));
            chk("b.pos_h",  32'(pos_h_b),  32'(m_ph[1]));
            chk("b.valid",  32'(valid_b),  32'(m_v[1]));
            chk("b.dir",    32'(dir_b),    32'(m_dir[1]));
            chk("b.bounce", 32'(bounce_b), 32'(m_bnc[1]));
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   // Drive tick/frame_start for the next edge; returns at the negedge after that edge's setup
   task automatic cyc(input logic t, input logic f);
      @(negedge clk);
      tick = t;
      frame_start = f;
   endtask

   // One tick with a frame every cycle; captures bounce after the tick edge and
   // returns once pos_h shows the post-tick position
   task automatic tick1(output logic ba, output logic bb);
      cyc(1'b1, 1'b1);
      cyc(1'b0, 1'b1);
      ba = bounce_a;
      bb = bounce_b;
      cyc(1'b0, 1'b1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   // ---------------- directed scenarios ----------------
   initial begin
      logic ba, bb;
      int   nb_a, nb_b;

      rst = 1'b0; enable = 1'b0; tick = 1'b0; frame_start = 1'b0; dir_init = 1'b1;
      left_bound = '0; right_bound = '0; step = '0;
      repeat (3) cyc(1'b0, 1'b0);

      chk("reset.pos_h",  32'(pos_h_a),  32'd0);
      chk("reset.valid",  32'(valid_a),  32'd0);
      chk("reset.dir",    32'(dir_a),    32'd1);
      chk("reset.bounce", 32'(bounce_a), 32'd0);

      // Long walk 0..200 step 4, pause, reverse
      left_bound = 10'd0; right_bound = 10'd200; step = 4'd4; dir_init = 1'b1;
      enable = 1'b1; rst = 1'b1;
      cyc(1'b0, 1'b1);
      cyc(1'b0, 1'b1);
      nb_a = 0; nb_b = 0;
      for (int i = 1; i <= 50; i++) begin
         tick1(ba, bb);
         nb_a += int'(ba); nb_b += int'(bb);
         if (i == 25) chk("walk.mid_pos", 32'(pos_h_a), 32'd100);
      end
      chk("walk.end_pos", 32'(pos_h_a), 32'd200);
      chk("walk.last_bounce", 32'(ba), 32'd1);
      chk("walk.bounces_a", 32'(nb_a), 32'd1);
      chk("walk.bounces_b", 32'(nb_b), 32'd1);
      for (int i = 0; i < 4; i++) tick1(ba, bb);
      chk("pause.dir_held", 32'(dir_a), 32'd1);
      chk("pause.pos_held", 32'(pos_h_a), 32'd200);
      tick1(ba, bb);
      chk("pause.reversed", 32'(dir_a), 32'd0);
      tick1(ba, bb);
      chk("walk_l.pos1", 32'(pos_h_a), 32'd196);
      tick1(ba, bb);
      chk("walk_l.pos2", 32'(pos_h_a), 32'd192);

      // Narrow bounds 10/21, clamp on both sides
      enable = 1'b0;
      cyc(1'b0, 1'b1);
      left_bound = 10'd10; right_bound = 10'd21; dir_init = 1'b1; enable = 1'b1;
      cyc(1'b0, 1'b1);
      cyc(1'b0, 1'b1);
      tick1(ba, bb); chk("narrow.r1", 32'(pos_h_a), 32'd14);
      tick1(ba, bb); chk("narrow.r2", 32'(pos_h_a), 32'd18);
      tick1(ba, bb); chk("narrow.r3", 32'(pos_h_a), 32'd21);
      chk("narrow.r_bounce", 32'(ba), 32'd1);
      chk("narrow.r_bounce_b", 32'(bb), 32'd1);
      for (int i = 0; i < 5; i++) tick1(ba, bb);
      chk("narrow.turn", 32'(dir_a), 32'd0);
      tick1(ba, bb); chk("narrow.l1", 32'(pos_h_a), 32'd17);
      tick1(ba, bb); chk("narrow.l2", 32'(pos_h_a), 32'd13);
      tick1(ba, bb); chk("narrow.l3", 32'(pos_h_a), 32'd10);
      chk("narrow.l_bounce", 32'(ba), 32'd1);

      // Tick coinciding with frame_start at position 40
      enable = 1'b0;
      cyc(1'b0, 1'b1);
      left_bound = 10'd0; right_bound = 10'd200; dir_init = 1'b1; enable = 1'b1;
      cyc(1'b0, 1'b1);
      for (int i = 0; i < 10; i++) tick1(ba, bb);
      chk("coinc.before", 32'(pos_h_a), 32'd40);
      cyc(1'b1, 1'b1);
      cyc(1'b0, 1'b0);
      chk("coinc.same_frame", 32'(pos_h_a), 32'd40);
      cyc(1'b0, 1'b1);
      chk("coinc.no_frame", 32'(pos_h_a), 32'd40);
      cyc(1'b0, 1'b0);
      chk("coinc.next_frame", 32'(pos_h_a), 32'd44);

      // Disable mid-WALK_L at 120, then restart rightward
      enable = 1'b0;
      cyc(1'b0, 1'b1);
      dir_init = 1'b0; enable = 1'b1;
      cyc(1'b0, 1'b1);
      cyc(1'b0, 1'b1);
      for (int i = 0; i < 20; i++) tick1(ba, bb);
      chk("dis.pos", 32'(pos_h_a), 32'd120);
      chk("dis.dir", 32'(dir_a), 32'd0);
      enable = 1'b0;
      cyc(1'b0, 1'b0);
      cyc(1'b0, 1'b0);
      chk("dis.valid_until_frame", 32'(valid_a), 32'd1);
      cyc(1'b0, 1'b1);
      cyc(1'b0, 1'b0);
      chk("dis.valid_low", 32'(valid_a), 32'd0);
      chk("dis.pos_hold", 32'(pos_h_a), 32'd120);
      for (int i = 0; i < 3; i++) tick1(ba, bb);
      chk("dis.pos_hold_ticks", 32'(pos_h_a), 32'd120);
      dir_init = 1'b1; enable = 1'b1;
      cyc(1'b0, 1'b1);
      cyc(1'b0, 1'b1);
      chk("reen.pos", 32'(pos_h_a), 32'd0);
      chk("reen.valid", 32'(valid_a), 32'd1);
      chk("reen.dir", 32'(dir_a), 32'd1);

      // Step 0, shrinking bound, underflow on left
      for (int i = 0; i < 5; i++) tick1(ba, bb);
      chk("mid.pos20", 32'(pos_h_a), 32'd20);
      step = 4'd0;
      tick1(ba, bb);
      chk("mid.step0", 32'(pos_h_a), 32'd20);
      step = 4'd4; right_bound = 10'd10;
      tick1(ba, bb);
      chk("mid.shrink_pos", 32'(pos_h_a), 32'd10);
      chk("mid.shrink_bounce", 32'(ba), 32'd1);
      for (int i = 0; i < 5; i++) tick1(ba, bb);
      step = 4'd15;
      tick1(ba, bb);
      chk("mid.underflow_pos", 32'(pos_h_a), 32'd0);
      chk("mid.underflow_bounce", 32'(ba), 32'd1);

      // Near the top of the 10-bit range
      enable = 1'b0;
      cyc(1'b0, 1'b1);
      left_bound = 10'd1000; right_bound = 10'd1023; dir_init = 1'b1; enable = 1'b1;
      cyc(1'b0, 1'b1);
      cyc(1'b0, 1'b1);
      tick1(ba, bb); chk("top.pos1", 32'(pos_h_a), 32'd1015);
      tick1(ba, bb); chk("top.pos2", 32'(pos_h_a), 32'd1023);
      chk("top.bounce", 32'(ba), 32'd1);

      // Reset during PAUSE overrides active inputs
      tick1(ba, bb);
      rst = 1'b0;
      cyc(1'b1, 1'b1);
      cyc(1'b0, 1'b0);
      chk("rst.pos_h_a", 32'(pos_h_a), 32'd0);
      chk("rst.valid_a", 32'(valid_a), 32'd0);
      chk("rst.dir_a", 32'(dir_a), 32'd1);
      chk("rst.bounce_a", 32'(bounce_a), 32'd0);
      chk("rst.pos_h_b", 32'(pos_h_b), 32'd0);

      // Zero pause: reversal on the tick after the bounce
      rst = 1'b1; left_bound = 10'd10; right_bound = 10'd21; step = 4'd4; dir_init = 1'b1;
      cyc(1'b0, 1'b1);
      cyc(1'b0, 1'b1);
      for (int i = 0; i < 3; i++) tick1(ba, bb);
      chk("p0.bounce", 32'(bb), 32'd1);
      tick1(ba, bb);
      chk("p0.reversed", 32'(dir_b), 32'd0);
      chk("p0.pause4_not_reversed", 32'(dir_a), 32'd1);
      chk("p0.pos_at_bound", 32'(pos_h_b), 32'd21);
      tick1(ba, bb);
      chk("p0.walk_left", 32'(pos_h_b), 32'd17);

      // Inverted bounds: stays idle
      enable = 1'b0;
      cyc(1'b0, 1'b1);
      left_bound = 10'd300; right_bound = 10'd100; enable = 1'b1;
      nb_a = 0; nb_b = 0;
      for (int i = 0; i < 100; i++) begin
         tick1(ba, bb);
         nb_a += int'(ba); nb_b += int'(bb);
      end
      chk("inv.bounces_a", 32'(nb_a), 32'd0);
      chk("inv.bounces_b", 32'(nb_b), 32'd0);
      chk("inv.valid", 32'(valid_a), 32'd0);
      chk("inv.pos", 32'(pos_h_a), 32'd300);

      repeat (3) cyc(1'b0, 1'b0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/soldier_walker.md
SOLDIER_WALKER -- requirements
Module: soldier_walker

Interface
REQ-001 The block SHALL have parameter PAUSE_TICKS, default 4, giving the number of ticks spent stationary at each bound (range 0-15).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous, active-low reset.
REQ-004 The block SHALL have port enable, input, 1 bit: walker active; low forces IDLE.
REQ-005 The block SHALL have port tick, input, 1 bit: one-cycle motion step strobe (slow-clock edge, already synchronised).
REQ-006 The block SHALL have port frame_start, input, 1 bit: one-cycle pulse at start of vertical blank.
REQ-007 The block SHALL have port dir_init, input, 1 bit: start direction; 1 = rightward, 0 = leftward.
REQ-008 The block SHALL have port left_bound, input, 10 bits: minimum position.
REQ-009 The block SHALL have port right_bound, input, 10 bits: maximum position.
REQ-010 The block SHALL have port step, input, 4 bits: pixels moved per tick; 0 means stationary.
REQ-011 The block SHALL have port pos_h, output, 10 bits: frame-latched horizontal position for the renderer.
REQ-012 The block SHALL have port valid, output, 1 bit: sprite visible; drives the renderer's valid input.
REQ-013 The block SHALL have port dir, output, 1 bit: current heading; 1 = right.
REQ-014 The block SHALL have port bounce, output, 1 bit: one-cycle pulse when a bound is reached.

Function
REQ-015 The block SHALL implement the states IDLE, WALK_R, WALK_L and PAUSE.
REQ-016 In IDLE with enable=1 and left_bound<right_bound, the block SHALL, on the next edge, load the internal position with left_bound if dir_init=1, else right_bound, and enter WALK_R or WALK_L accordingly, with dir=dir_init.
REQ-017 In IDLE with left_bound>=right_bound, the block SHALL remain in IDLE with the internal position set to left_bound and valid=0.
REQ-018 In WALK_R, on tick, the block SHALL compute the next position as pos+step at 11-bit width; if the result is >= right_bound, the position SHALL be clamped to right_bound, bounce SHALL pulse for one cycle, and the state SHALL become PAUSE.
REQ-019 In WALK_L, on tick, the block SHALL compute the next position as pos-step at 11-bit signed width; if the result is <= left_bound (including underflow), the position SHALL be clamped to left_bound, bounce SHALL pulse, and the state SHALL become PAUSE.
REQ-020 In PAUSE, the block SHALL count ticks; when the count equals PAUSE_TICKS it SHALL invert dir, clear the counter, and enter the walk state for the new dir; with PAUSE_TICKS=0 it SHALL leave PAUSE on the first tick after entry.
REQ-021 Cycles without tick SHALL change neither the position nor the pause counter.
REQ-022 When enable=0 in any state, the block SHALL go to IDLE on the next edge, set valid=0, and hold pos_h; re-enabling SHALL restart per REQ-016.
REQ-023 pos_h SHALL be updated from the internal position only on cycles with frame_start=1; when tick and frame_start coincide, pos_h SHALL take the internal position as registered before that edge (one frame of latency, no tearing).
REQ-024 valid SHALL be 1 exactly when the state is not IDLE, registered and updated on the same frame_start edges as pos_h.
REQ-025 Bounds or step changing mid-walk SHALL take effect at the next tick; a position already outside new bounds SHALL clamp on that tick and bounce.

Reset
REQ-026 On rst=0 at a clock edge, the block SHALL set state=IDLE, internal position=0, pos_h=0, valid=0, dir=1, bounce=0 and pause counter=0, overriding all other inputs including mid-walk and mid-pause.

Verification
REQ-027 Scenario: bounds 0/200, step 4, dir_init 1, enable 1 -> after 50 ticks the position is 200, bounce pulses once, then 4 ticks of pause, then dir=0 and the position decreases by 4 per tick.
REQ-028 Scenario: bounds 10/21, step 4, rightward from 10 -> positions 14, 18, 21 (clamped) with bounce on the third tick; leftward run 17, 13, 10 with bounce.
REQ-029 Scenario: tick and frame_start asserted in the same cycle at internal position 40 with step 4 -> pos_h=40 that frame and 44 at the next frame_start.
REQ-030 Scenario: enable dropped mid-WALK_L at position 120 -> IDLE; valid=0 at the next frame_start; pos_h holds 120; re-enable with dir_init=1 -> restart at left_bound.
REQ-031 Scenario: left_bound=300, right_bound=100 -> stays IDLE, valid=0, no bounce for 100 ticks.
REQ-032 Scenario: rst=0 during PAUSE -> next cycle all outputs are at reset values; with PAUSE_TICKS=0, bounce is followed by reversal on the next tick.
